msk_add_wtk_seq: RTL and testbench

MSK_ADD_WTK_SEQ -- requirements
Module: msk_add_wtk_seq

---
 rtl/msk_add_wtk_seq_pkg.sv | 17 +
 rtl/msk_wtk_sched.sv | 75 +++++++
 rtl/msk_add_wtk_seq.sv | 102 ++++++++++
 tb/tb_msk_add_wtk_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_add_wtk_seq_pkg.sv
// Shared definitions for the masked add-tweakey sequencer: LFSR seed and step,
// plus the bit/share index helper for the interleaved sharing layout.
package msk_add_wtk_seq_pkg;

    localparam logic [3:0] LFSR_SEED = 4'b0001;

    function automatic logic [3:0] lfsr_step(input logic [3:0] w);
        return {w[2:0], w[3] ^ w[2]};
    endfunction

    // Bit b of share j lives at d*b+j in a sharing bundle.
    function automatic int unsigned share_idx(input int unsigned b, input int unsigned j,
                                              input int unsigned d);
        return d * b + j;
    endfunction

endpackage

// File: rtl/msk_wtk_sched.sv
// Step schedule for the masked add-tweakey sequencer: step counter, round
// constant LFSR, public tweak register and odd/even control.
module msk_wtk_sched
    import msk_add_wtk_seq_pkg::*;
#(
    parameter int unsigned Nbits  = 128,
    parameter int unsigned NSTEPS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Nbits-1:0] tweak_in,
    input  logic             advance,
    output logic             busy,
    output logic [5:0]       step_idx,
    output logic [3:0]       w,
    output logic             odd,
    output logic [Nbits-1:0] delta,
    output logic             last_step
);

    localparam int unsigned H = Nbits / 2;

    logic             busy_q, busy_d;
    logic [5:0]       step_q, step_d;
    logic [3:0]       w_q, w_d;
    logic [Nbits-1:0] delta_q, delta_d;

    assign busy      = busy_q;
    assign step_idx  = step_q;
    assign w         = w_q;
    assign delta     = delta_q;
    assign odd       = step_q[0];
    assign last_step = (step_q == 6'(NSTEPS - 1));

    always_comb begin
        busy_d  = busy_q;
        step_d  = step_q;
        w_d     = w_q;
        delta_d = delta_q;
        if (start) begin
            busy_d  = 1'b1;
            step_d  = '0;
            w_d     = LFSR_SEED;
            delta_d = tweak_in;
        end else if (advance) begin
            w_d = lfsr_step(w_q);
            // The tweak only evolves after it has been consumed on an odd step.
            if (odd) begin
                delta_d = {delta_q[H-1:0], delta_q[Nbits-1:H] ^ delta_q[H-1:0]};
            end
            if (last_step) begin
                step_d = '0;
                busy_d = 1'b0;
            end else begin
                step_d = step_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            step_q  <= '0;
            w_q     <= LFSR_SEED;
            delta_q <= '0;
        end else begin
            busy_q  <= busy_d;
            step_q  <= step_d;
            w_q     <= w_d;
            delta_q <= delta_d;
        end
    end

endmodule

// File: rtl/msk_add_wtk_seq.sv
// Masked add-round-tweakey sequencer: one step per accepted input, registered
// output with valid/ready handshake and last-step marking.
module msk_add_wtk_seq
    import msk_add_wtk_seq_pkg::*;
#(
    parameter int unsigned Nbits  = 128,
    parameter int unsigned d      = 2,
    parameter int unsigned NSTEPS = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [Nbits-1:0]   tweak_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [d*Nbits-1:0] sharing_bundle_in,
    input  logic [d*Nbits-1:0] sharing_K,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [d*Nbits-1:0] sharing_bundle_out,
    output logic [5:0]         step_idx,
    output logic               busy,
    output logic               last_out
);

    localparam int unsigned R = Nbits / 4;

    logic               xfer;
    logic [3:0]         w;
    logic               odd;
    logic [Nbits-1:0]   delta;
    logic               last_step;
    logic [Nbits-1:0]   pub;
    logic [d*Nbits-1:0] res;

    logic               out_valid_q;
    logic               last_q;
    logic [d*Nbits-1:0] out_q;

    assign in_ready           = busy && (!out_valid_q || out_ready) && !start;
    assign xfer               = in_valid && in_ready;
    assign out_valid          = out_valid_q;
    assign last_out           = last_q;
    assign sharing_bundle_out = out_q;

    msk_wtk_sched #(
        .Nbits  (Nbits),
        .NSTEPS (NSTEPS)
    ) u_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tweak_in  (tweak_in),
        .advance   (xfer),
        .busy      (busy),
        .step_idx  (step_idx),
        .w         (w),
        .odd       (odd),
        .delta     (delta),
        .last_step (last_step)
    );

    // Public part of this step's tweakey: tweak on odd steps plus the row constants.
    always_comb begin
        pub = odd ? delta : '0;
        for (int unsigned r = 0; r < 4; r++) begin
            pub[R*r] = pub[R*r] ^ w[r];
        end
    end

    // Public values enter share 0 only; key shares are added share-wise on odd steps.
    always_comb begin
        res = sharing_bundle_in;
        for (int unsigned b = 0; b < Nbits; b++) begin
            for (int unsigned j = 0; j < d; j++) begin
                if (j == 0) begin
                    res[share_idx(b, j, d)] = sharing_bundle_in[share_idx(b, j, d)] ^ pub[b]
                                            ^ (odd & sharing_K[share_idx(b, j, d)]);
                end else begin
                    res[share_idx(b, j, d)] = sharing_bundle_in[share_idx(b, j, d)]
                                            ^ (odd & sharing_K[share_idx(b, j, d)]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            out_q       <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            last_q      <= last_step;
            out_q       <= res;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msk_add_wtk_seq.sv
// Scoreboard bench for msk_add_wtk_seq: driver pushes expected results from a
// step-rule reference model, monitor pops and compares on every consumed output.
module tb_msk_add_wtk_seq;

    localparam int unsigned N  = 128;
    localparam int unsigned D  = 2;
    localparam int unsigned NS = 12;
    localparam int unsigned R  = N / 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   tweak_in = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [D*N-1:0] sharing_bundle_in = '0;
    logic [D*N-1:0] sharing_K = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [D*N-1:0] sharing_bundle_out;
    logic [5:0]     step_idx;
    logic           busy;
    logic           last_out;

    msk_add_wtk_seq #(
        .Nbits  (N),
        .d      (D),
        .NSTEPS (NS)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .tweak_in           (tweak_in),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .sharing_bundle_in  (sharing_bundle_in),
        .sharing_K          (sharing_K),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .sharing_bundle_out (sharing_bundle_out),
        .step_idx           (step_idx),
        .busy               (busy),
        .last_out           (last_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [D*N-1:0] data;
        logic           last;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           tb_step = 0;
    logic [N-1:0] tb_tweak = '0;
    logic         rand_bp = 1'b0;

    task automatic chk(input string name, input logic [D*N-1:0] act, input logic [D*N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Step s of a run: W is the LFSR after s advances, the tweak after (s/2) odd updates.
    function automatic logic [D*N-1:0] model(input int s, input logic [D*N-1:0] din,
                                             input logic [D*N-1:0] k, input logic [N-1:0] tw);
        logic [3:0]     wv;
        logic [N-1:0]   dl;
        logic [N-1:0]   pub;
        logic [D*N-1:0] o;
        wv = 4'b0001;
        dl = tw;
        for (int i = 0; i < s; i++) wv = {wv[2:0], wv[3] ^ wv[2]};
        for (int i = 1; i < s; i += 2) dl = {dl[N/2-1:0], dl[N-1:N/2] ^ dl[N/2-1:0]};
        pub = (s % 2 == 1) ? dl : '0;
        for (int r = 0; r < 4; r++) pub[R*r] = pub[R*r] ^ wv[r];
        o = din;
        if (s % 2 == 1) o = o ^ k;
        for (int b = 0; b < N; b++) o[D*b] = o[D*b] ^ pub[b];
        return o;
    endfunction

    function automatic logic [D*N-1:0] rnd_wide();
        logic [D*N-1:0] v;
        for (int i = 0; i < D * N / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [D*N-1:0] din, input int gap);
        exp_t e;
        bit   done;
        done = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        sharing_bundle_in = din;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("step_idx", D*N'(step_idx), D*N'(tb_step));
                e.data = model(tb_step, din, sharing_K, tb_tweak);
                e.last = (tb_step == NS - 1);
                sb.push_back(e);
                tb_step = (tb_step == NS - 1) ? 0 : tb_step + 1;
                done = 1'b1;
            end
            tick();
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no in_ready want in_ready within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [N-1:0] tw, input logic [D*N-1:0] k);
        start = 1'b1;
        tweak_in = tw;
        sharing_K = k;
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_on_start", D*N'(in_ready), '0);
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        tb_step = 0;
        tb_tweak = tw;
        @(negedge clk);
        chk("busy_after_start", D*N'(busy), D*N'(1));
        chk("step_after_start", D*N'(step_idx), '0);
        tick();
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        rand_bp = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            tick();
            if (sb.size() == 0 && !out_valid) ok = 1'b1;
        end
        chk("drain", D*N'(ok), D*N'(1));
    endtask

    // Monitor: compares each consumed output and the hold behaviour under back-pressure.
    logic [D*N-1:0] held;
    bit             stalled_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) chk("hold_out", sharing_bundle_out, held);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got %h want none", sharing_bundle_out);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", sharing_bundle_out, e.data);
                        chk("last_out", D*N'(last_out), D*N'(e.last));
                    end
                end
                stalled_prev = out_valid && !out_ready;
                held = sharing_bundle_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D*N-1:0] x;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_out_valid", D*N'(out_valid), '0);
        chk("rst_busy", D*N'(busy), '0);
        chk("rst_last", D*N'(last_out), '0);
        chk("rst_step", D*N'(step_idx), '0);
        chk("rst_bundle", sharing_bundle_out, '0);
        chk("rst_in_ready", D*N'(in_ready), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // All-zero run: outputs carry only the row constants.
        out_ready = 1'b1;
        do_start('0, '0);
        for (int i = 0; i < NS; i++) send('0, 0);
        @(negedge clk);
        chk("busy_after_last", D*N'(busy), '0);
        chk("step_after_last", D*N'(step_idx), '0);
        drain();

        // Known tweak, zero key.
        do_start({64'h1, 64'h2}, '0);
        for (int i = 0; i < 4; i++) send('0, 0);
        drain();

        // Random runs with random gaps and back-pressure.
        for (int run = 0; run < 3; run++) begin
            do_start(N'(rnd_wide()), rnd_wide());
            rand_bp = 1'b1;
            for (int i = 0; i < NS; i++) send(rnd_wide(), $urandom_range(0, 2));
            drain();
        end

        // Stall after the first output.
        out_ready = 1'b1;
        do_start(N'(rnd_wide()), rnd_wide());
        send(rnd_wide(), 0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        sharing_bundle_in = rnd_wide();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", D*N'(in_ready), '0);
            chk("stall_step", D*N'(step_idx), D*N'(1));
            chk("stall_valid", D*N'(out_valid), D*N'(1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(rnd_wide(), 0);
        send(rnd_wide(), 0);
        drain();

        // Abort at step 5 with a pending output held back.
        do_start(N'(rnd_wide()), rnd_wide());
        for (int i = 0; i < 5; i++) send(rnd_wide(), 0);
        out_ready = 1'b0;
        do_start(N'(rnd_wide()), sharing_K);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(rnd_wide(), 0);
        drain();

        // Asynchronous reset mid-run.
        do_start(N'(rnd_wide()), rnd_wide());
        for (int i = 0; i < 3; i++) send(rnd_wide(), 0);
        out_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", D*N'(out_valid), '0);
        chk("arst_busy", D*N'(busy), '0);
        chk("arst_last", D*N'(last_out), '0);
        chk("arst_step", D*N'(step_idx), '0);
        chk("arst_bundle", sharing_bundle_out, '0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        sharing_bundle_in = rnd_wide();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", D*N'(in_ready), '0);
            chk("idle_out_valid", D*N'(out_valid), '0);
            tick();
        end
        in_valid = 1'b0;
        x = rnd_wide();
        do_start(N'(x), rnd_wide());
        for (int i = 0; i < NS; i++) send(rnd_wide(), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
